// File: rtl/pid_cfg_pkg.sv
// Shared constants and types for the PID configuration sequencer:
// register address map, ctrl bit positions and default reset values.
package pid_cfg_pkg;

    localparam logic [3:0] ADDR_SP   = 4'd0;
    localparam logic [3:0] ADDR_KP   = 4'd1;
    localparam logic [3:0] ADDR_KI   = 4'd2;
    localparam logic [3:0] ADDR_KD   = 4'd3;
    localparam logic [3:0] ADDR_PER  = 4'd4;
    localparam logic [3:0] ADDR_CTRL = 4'd5;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_CLR = 1;

    localparam logic [3:0] SP_RST_DEF  = 4'b1011;
    localparam logic [3:0] KP_RST_DEF  = 4'd5;
    localparam logic [3:0] KI_RST_DEF  = 4'd3;
    localparam logic [3:0] KD_RST_DEF  = 4'd2;
    localparam logic [3:0] PER_RST_DEF = 4'd0;
    localparam logic       RUN_RST_DEF = 1'b1;

    typedef enum logic {ST_ADDR, ST_DATA} cfg_state_e;

    typedef struct packed {
        logic [3:0] sp;
        logic [3:0] kp;
        logic [3:0] ki;
        logic [3:0] kd;
        logic [3:0] per;
    } cfg_regs_t;

endpackage

// File: rtl/pid_cfg_sequencer_if.sv
// Nibble-serial configuration stream from the I/O pins.
interface pid_cfg_sequencer_if;
    logic       cfg_valid;
    logic [3:0] cfg_data;

    modport master (output cfg_valid, output cfg_data);
    modport slave  (input  cfg_valid, input  cfg_data);
endinterface

// File: rtl/pid_sample_timer.sv
// Prescaler plus period counter; tick marks the last cycle of a sample period
// and pv_stb follows it by one cycle.
module pid_sample_timer #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_i,
    input  logic       clr_i,
    input  logic [3:0] period_active_i,
    output logic       tick_o,
    output logic       pv_stb_o
);

    logic [PRESCALE-1:0] pre_q, pre_d;
    logic [3:0]          per_q, per_d;
    logic                stb_q;
    logic                pre_max;

    assign pre_max  = &pre_q;
    assign tick_o   = run_i && pre_max && (per_q == period_active_i);
    assign pv_stb_o = stb_q;

    always_comb begin
        pre_d = pre_q + 1'b1;
        per_d = per_q;
        if (pre_max)
            per_d = (per_q == period_active_i) ? 4'd0 : per_q + 4'd1;
        // Stopped or cleared: hold at zero so a restart begins a full period.
        if (clr_i || !run_i) begin
            pre_d = '0;
            per_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            per_q <= 4'd0;
            stb_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            per_q <= per_d;
            stb_q <= tick_o;
        end
    end

endmodule

// File: rtl/pid_cfg_sequencer.sv
// Nibble-serial config FSM with shadow/active registers committed atomically
// at sample boundaries, driving the PID core's constants and sample strobe.
module pid_cfg_sequencer
    import pid_cfg_pkg::*;
#(
    parameter int         PRESCALE = 4,
    parameter logic [3:0] SP_RST   = SP_RST_DEF,
    parameter logic [3:0] KP_RST   = KP_RST_DEF,
    parameter logic [3:0] KI_RST   = KI_RST_DEF,
    parameter logic [3:0] KD_RST   = KD_RST_DEF,
    parameter logic [3:0] PER_RST  = PER_RST_DEF,
    parameter logic       RUN_RST  = RUN_RST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pid_cfg_sequencer_if.slave  cfg,
    output logic [3:0]          sp,
    output logic [3:0]          kp,
    output logic [3:0]          ki,
    output logic [3:0]          kd,
    output logic                pv_stb,
    output logic                pid_rst,
    output logic                running,
    output logic                pending,
    output logic                cfg_err
);

    localparam cfg_regs_t REGS_RST = '{sp: SP_RST, kp: KP_RST, ki: KI_RST,
                                       kd: KD_RST, per: PER_RST};

    cfg_state_e state_q, state_d;
    logic [3:0] addr_q, addr_d;
    cfg_regs_t  act_q, act_d, sh_q, sh_d;
    logic       run_q, run_d, pend_q, pend_d, err_q, err_d, clr_q, clr_d;
    logic       tick, commit;

    pid_sample_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk             (clk),
        .reset           (reset),
        .run_i           (run_q),
        .clr_i           (clr_q),
        .period_active_i (act_q.per),
        .tick_o          (tick),
        .pv_stb_o        (pv_stb)
    );

    // While stopped there is no sample boundary, so commit on the next cycle.
    assign commit = pend_q && (tick || !run_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        act_d   = act_q;
        sh_d    = sh_q;
        run_d   = run_q;
        pend_d  = pend_q;
        err_d   = err_q;
        clr_d   = 1'b0;
        if (commit) begin
            act_d  = sh_q;
            pend_d = 1'b0;
        end
        if (cfg.cfg_valid) begin
            case (state_q)
                ST_ADDR: begin
                    addr_d  = cfg.cfg_data;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    state_d = ST_ADDR;
                    // A write racing a commit lands after the copy and stays pending.
                    case (addr_q)
                        ADDR_SP:   begin sh_d.sp  = cfg.cfg_data; pend_d = 1'b1; end
                        ADDR_KP:   begin sh_d.kp  = cfg.cfg_data; pend_d = 1'b1; end
                        ADDR_KI:   begin sh_d.ki  = cfg.cfg_data; pend_d = 1'b1; end
                        ADDR_KD:   begin sh_d.kd  = cfg.cfg_data; pend_d = 1'b1; end
                        ADDR_PER:  begin sh_d.per = cfg.cfg_data; pend_d = 1'b1; end
                        ADDR_CTRL: begin
                            run_d = cfg.cfg_data[CTRL_RUN];
                            clr_d = cfg.cfg_data[CTRL_CLR];
                        end
                        default:   err_d = 1'b1;
                    endcase
                end
                default: state_d = ST_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ADDR;
            addr_q  <= 4'd0;
            act_q   <= REGS_RST;
            sh_q    <= REGS_RST;
            run_q   <= RUN_RST;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            act_q   <= act_d;
            sh_q    <= sh_d;
            run_q   <= run_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
        end
    end

    assign sp      = act_q.sp;
    assign kp      = act_q.kp;
    assign ki      = act_q.ki;
    assign kd      = act_q.kd;
    assign running = run_q;
    assign pending = pend_q;
    assign cfg_err = err_q;
    assign pid_rst = reset | clr_q;

endmodule

// File: tb/tb_pid_cfg_sequencer.sv
// Bench for pid_cfg_sequencer: per-cycle reference model plus table vectors
// and hand-written timing sequences.
module tb_pid_cfg_sequencer;

    localparam int PRE = 2;
    localparam int PS  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sp, kp, ki, kd;
    logic       pv_stb, pid_rst, running, pending, cfg_err;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    pid_cfg_sequencer_if cfg_if();

    pid_cfg_sequencer #(.PRESCALE(PRE)) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg     (cfg_if),
        .sp      (sp),
        .kp      (kp),
        .ki      (ki),
        .kd      (kd),
        .pv_stb  (pv_stb),
        .pid_rst (pid_rst),
        .running (running),
        .pending (pending),
        .cfg_err (cfg_err)
    );

    // Reference model: one elapsed-cycle counter per sample period.
    logic [3:0] m_act[5];
    logic [3:0] m_sh[5];
    logic [3:0] m_addr;
    bit         m_run, m_pend, m_err, m_clr, m_stb, m_have;
    int         m_el;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit r);
        bit tk, cm, nclr;
        int nel;
        if (r) begin
            m_act  = '{4'hB, 4'd5, 4'd3, 4'd2, 4'd0};
            m_sh   = '{4'hB, 4'd5, 4'd3, 4'd2, 4'd0};
            m_addr = 4'd0;
            m_run = 1; m_pend = 0; m_err = 0; m_clr = 0; m_stb = 0; m_have = 0;
            m_el = 0;
        end else begin
            tk   = m_run && (m_el == (int'(m_act[4]) + 1) * PS - 1);
            cm   = m_pend && (tk || !m_run);
            nel  = (m_clr || !m_run || tk) ? 0 : m_el + 1;
            nclr = 0;
            m_stb = tk;
            if (cm) begin
                m_act  = m_sh;
                m_pend = 0;
            end
            if (v) begin
                if (!m_have) begin
                    m_addr = d;
                    m_have = 1;
                end else begin
                    m_have = 0;
                    if (m_addr <= 4) begin
                        m_sh[int'(m_addr)] = d;
                        m_pend = 1;
                    end else if (m_addr == 5) begin
                        m_run = d[0];
                        nclr  = d[1];
                    end else begin
                        m_err = 1;
                    end
                end
            end
            m_clr = nclr;
            m_el  = nel;
        end
    endtask

    task automatic cyc(input bit v, input logic [3:0] d, input bit r);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_data  = d;
        reset            = r;
        @(posedge clk);
        model_step(v, d, r);
        #1;
        chk("cycle_outputs",
            {11'd0, sp, kp, ki, kd, pv_stb, pid_rst, running, pending, cfg_err},
            {11'd0, m_act[0], m_act[1], m_act[2], m_act[3], m_stb, r | m_clr,
             m_run, m_pend, m_err});
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic wait_stb(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            n++;
            if (pv_stb) return;
        end
        chk("stb_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0] a, d;
        logic [3:0] e_sp, e_kp, e_ki, e_kd;
        logic       e_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, cnt;
        bit ok;
        logic [15:0] snap;
        bit v, r;
        logic [3:0] d;

        tbl[0] = '{4'd0,  4'd6,  4'd6,  4'd5, 4'd3,  4'd2, 1'b0};
        tbl[1] = '{4'd1,  4'd1,  4'd6,  4'd1, 4'd3,  4'd2, 1'b0};
        tbl[2] = '{4'd2,  4'd15, 4'd6,  4'd1, 4'd15, 4'd2, 1'b0};
        tbl[3] = '{4'd3,  4'd0,  4'd6,  4'd1, 4'd15, 4'd0, 1'b0};
        tbl[4] = '{4'd4,  4'd2,  4'd6,  4'd1, 4'd15, 4'd0, 1'b0};
        tbl[5] = '{4'd7,  4'd9,  4'd6,  4'd1, 4'd15, 4'd0, 1'b1};
        tbl[6] = '{4'd0,  4'd10, 4'd10, 4'd1, 4'd15, 4'd0, 1'b1};
        tbl[7] = '{4'd15, 4'd3,  4'd10, 4'd1, 4'd15, 4'd0, 1'b1};

        // Reset state
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1);
        chk("rst_sp", sp, 4'b1011);
        chk("rst_kp", kp, 4'd5);
        chk("rst_ki", ki, 4'd3);
        chk("rst_kd", kd, 4'd2);
        chk("rst_flags", {pv_stb, pending, cfg_err, running, pid_rst}, 5'b00011);

        // Period 0: strobe every 4 cycles, first one 4 cycles after reset
        cyc(1'b0, 4'd0, 1'b0);
        wait_stb(n);
        chk("first_stb_gap", n, 3);
        wait_stb(n);
        chk("stb_gap_p0_a", n, 4);
        wait_stb(n);
        chk("stb_gap_p0_b", n, 4);

        // Period write: current period completes with old spacing, then 16
        wr(4'd4, 4'd3);
        chk("per_pending", pending, 1);
        wait_stb(n);
        chk("per_old_gap", n, 2);
        chk("per_commit_pend", pending, 0);
        wait_stb(n);
        chk("stb_gap_p3", n, 16);

        // kp write mid-period: new kp coincides with pv_stb
        repeat (3) cyc(1'b0, 4'd0, 1'b0);
        wr(4'd1, 4'd9);
        chk("kp_pending", pending, 1);
        ok = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            if (pv_stb) break;
            if (kp !== 4'd5) ok = 0;
        end
        chk("kp_held", ok, 1);
        chk("kp_at_stb", {pv_stb, kp, pending}, {1'b1, 4'd9, 1'b0});

        // Stop, write while stopped, restart
        wr(4'd5, 4'd0);
        repeat (2) cyc(1'b0, 4'd0, 1'b0);
        wr(4'd0, 4'd7);
        chk("stop_sp_pre", {sp, pending}, {4'hB, 1'b1});
        cyc(1'b0, 4'd0, 1'b0);
        chk("stop_sp_post", {sp, pending}, {4'd7, 1'b0});
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            if (pv_stb) cnt++;
        end
        chk("stopped_no_stb", cnt, 0);
        wr(4'd5, 4'd1);
        chk("restart_running", running, 1);
        wait_stb(n);
        chk("restart_gap", n, 16);

        // Clear pulse: one cycle, counters restart
        wr(4'd5, 4'd3);
        chk("clr_pulse", {pid_rst, running}, 2'b11);
        cyc(1'b0, 4'd0, 1'b0);
        chk("clr_pulse_end", pid_rst, 0);
        wait_stb(n);
        chk("clr_restart_gap", n, 16);

        // Undefined address: sticky error, no register changes
        snap = {sp, kp, ki, kd};
        wr(4'd12, 4'd5);
        chk("err_set", cfg_err, 1);
        repeat (5) cyc(1'b0, 4'd0, 1'b0);
        chk("err_sticky", cfg_err, 1);
        chk("err_no_change", {sp, kp, ki, kd, pending}, {snap, 1'b0});

        // Reset while in DATA: stale address discarded
        cyc(1'b1, 4'd2, 1'b0);
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0);
        wr(4'd2, 4'd4);
        chk("rst_data_pre", {ki, pending, cfg_err}, {4'd3, 1'b1, 1'b0});
        wait_stb(n);
        chk("rst_data_ki", {ki, cfg_err}, {4'd4, 1'b0});

        // Table vectors with the timer stopped
        cyc(1'b0, 4'd0, 1'b1);
        wr(4'd5, 4'd0);
        foreach (tbl[i]) begin
            wr(tbl[i].a, tbl[i].d);
            cyc(1'b0, 4'd0, 1'b0);
            chk($sformatf("tbl_%0d", i), {sp, kp, ki, kd, cfg_err},
                {tbl[i].e_sp, tbl[i].e_kp, tbl[i].e_ki, tbl[i].e_kd, tbl[i].e_err});
        end

        // Random traffic against the model
        cyc(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 2) != 0);
            d = 4'($urandom_range(0, 15));
            cyc(v, d, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pid_cfg_sequencer.md
Name: pid_cfg_sequencer

Overview:
Configuration and sample-scheduling controller for the PID core.
- Accepts a nibble-serial write stream from the I/O pins into shadow registers for sp, kp, ki and kd.
- Commits the shadow registers atomically at sample boundaries.
- Generates the pv_stb sample strobe at a programmable period, and a one-cycle PID clear.
- Replaces the fixed constants and free-running strobe in the top-level wrapper.

Parameters:
- PRESCALE, 4, log2 of the prescaler; one period unit is 2^PRESCALE clk cycles.
- SP_RST, 4'b1011, reset value of the active and shadow sp.
- KP_RST, 4'd5, reset value of kp.
- KI_RST, 4'd3, reset value of ki.
- KD_RST, 4'd2, reset value of kd.
- PER_RST, 4'd0, reset value of the period register.
- RUN_RST, 1'b1, reset value of the run bit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  cfg_data carries a nibble this cycle.
- cfg_data  in  4  address or data nibble.
- sp  out  4  active setpoint to the PID.
- kp  out  4  active proportional gain.
- ki  out  4  active integral gain.
- kd  out  4  active derivative gain.
- pv_stb  out  1  one-cycle sample strobe to the PID.
- pid_rst  out  1  reset to the PID core: reset OR the clear pulse.
- running  out  1  current run bit.
- pending  out  1  shadow differs from active (dirty flag).
- cfg_err  out  1  sticky: a write targeted an undefined address.

Behaviour:
- Reset values, synchronous on reset=1:
  - active and shadow regs = *_RST; period = PER_RST; run = RUN_RST.
  - pv_stb=0, pending=0, cfg_err=0, counters=0, FSM=ADDR.
- All outputs are registered. pid_rst is combinational: reset OR the registered clear pulse.
- FSM states are ADDR and DATA; a nibble is consumed only on cycles with cfg_valid=1.
  - ADDR, cfg_valid: latch cfg_data as addr, go to DATA.
  - DATA, cfg_valid: perform the write, return to ADDR.
  - Idle cycles (cfg_valid=0) never change state; there is no timeout.
- Address map:
  - 0=sp, 1=kp, 2=ki, 3=kd, 4=period: write the shadow register, set pending.
  - 5=ctrl, takes effect on the next cycle:
    - bit0 = run.
    - bit1 = clear; writing 1 pulses pid_rst for exactly one cycle and zeroes both counters.
    - bits 3:2 are ignored.
  - 6..15: data nibble is discarded and cfg_err is set.
- Timer:
  - Prescaler pre counts 0..2^PRESCALE-1.
  - Period counter per counts 0..period_active; it advances when pre wraps.
  - tick = run AND pre at max AND per == period_active.
  - Strobe spacing is (period_active+1)*2^PRESCALE cycles.
  - pv_stb is asserted in the cycle after tick.
- Commit:
  - On tick with pending=1: active <= shadow (sp, kp, ki, kd, period) and pending <= 0.
  - The new values are visible in the same cycle as the corresponding pv_stb.
- run=0:
  - Counters are held at 0 and no strobes are issued.
  - Shadow writes commit on the next cycle, so pending is high for exactly one cycle.
- run 0→1: counters start from 0; the first strobe comes after a full period.
- run 1→0 mid-period: counters clear next cycle; no strobe is issued.
- Shadow write in the same cycle as tick: the commit copies the pre-write shadow, and the written value lands in shadow with pending remaining 1.
- A period change takes effect only at commit; the current period always completes with the old value.
- Reset in DATA state: the partial address is discarded and the FSM is in ADDR.
- All widths are 4 bits, with no saturation logic. Counter widths are PRESCALE and 4 bits.

Decomposition:
- Package pid_cfg_pkg holds:
  - address constants ADDR_SP..ADDR_CTRL.
  - ctrl bit indices CTRL_RUN and CTRL_CLR.
  - default reset constants.
- Sub-module pid_sample_timer holds the prescaler, period counter and tick/pv_stb generation.
  - Inputs: run, period_active, clr.
  - Output: tick, pv_stb.
- The top level holds the FSM, shadow/active registers and commit logic.

Test Plan:
- Reset, PRESCALE=2, PER_RST=0 → sp=1011, kp=5, ki=3, kd=2; pv_stb pulses every 4 cycles; pending=0; cfg_err=0.
- Write {4,3} (period=3) → pending=1 until the next tick; subsequent pv_stb spacing is 16 cycles; the period in progress when written keeps the old spacing.
- Write {1,9} mid-period → kp stays 5 until the strobe cycle; kp=9 coincides with pv_stb=1; pending drops the same cycle.
- Write {5,0} (stop), then {0,7} → no pv_stb; sp=7 one cycle after the data nibble. Then write {5,1} → first pv_stb after exactly (period+1)*4 cycles.
- Write {5,3} → pid_rst high for exactly one cycle; counters restart; run stays 1. Write {12,5} → cfg_err=1 sticky; no register changes.
- Send address nibble 2, assert reset, then send {2,4} → ki=4 committed at the next tick; no stale address is used.
